// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
//
// Memory-mapped UART transmitter with a TX FIFO. Software pushes bytes into
// TXDATA; the frame FSM drains the FIFO and sends frames back-to-back with no
// idle gap between them. Frame format is start bit, DATA_BITS payload bits
// (LSB first), an optional parity bit and one or two stop bits.
//
// Ports
//   clk_i    : clock, all state updates on the rising edge
//   rst_i    : synchronous active-high reset
//   cs_i     : peripheral select
//   we_i     : write strobe, qualified by cs_i
//   addr_i   : word offset (0 TXDATA, 1 STATUS, 2 CTRL, 3 reserved)
//   wdata_i  : write data
//   rdata_o  : combinational read data, zero unless a read is selected
//   tx_o     : registered serial line, idle high
//   busy_o   : frame FSM is not idle
//   irq_o    : transmit-done interrupt (irq_en & FIFO empty & ~busy)
//
// Register map
//   TXDATA W : push wdata_i[DATA_BITS-1:0]; reads 0
//   STATUS R : [0] full [1] empty [2] busy [3] overflow [15:8] count
//          W : wdata_i[3]=1 clears the sticky overflow flag
//   CTRL  RW : [0] irq_en
// ---------------------------------------------------------------------------
module uart_tx_buffered #(
   parameter int DW         = 32,
   parameter int CLOCK_FREQ = 100000000,
   parameter int BAUD_RATE  = 9600,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          cs_i,
   input  logic          we_i,
   input  logic [1:0]    addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o,
   output logic          tx_o,
   output logic          busy_o,
   output logic          irq_o
);

   localparam int DIVISOR = CLOCK_FREQ / BAUD_RATE;
   localparam int BAUD_W  = $clog2(DIVISOR);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int BIT_W   = $clog2(DATA_BITS);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIVISOR - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // ------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------
   logic wr_txdata;
   logic wr_status;
   logic wr_ctrl;

   assign wr_txdata = cs_i & we_i & (addr_i == 2'd0);
   assign wr_status = cs_i & we_i & (addr_i == 2'd1);
   assign wr_ctrl   = cs_i & we_i & (addr_i == 2'd2);

   // Upper write-data bits have no register behind them.
   logic unused_wdata;
   assign unused_wdata = &{1'b0, wdata_i};

   // ------------------------------------------------------------------
   // FIFO storage and control
   // ------------------------------------------------------------------
   logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_reg;
   logic [PTR_W-1:0]     rd_ptr_reg;
   logic [CNT_W-1:0]     count_reg;
   logic                 overflow_reg;
   logic                 irq_en_reg;

   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 pop;
   logic                 push_ok;
   logic                 overflow_evt;
   logic [DATA_BITS-1:0] head_data;

   assign fifo_full  = (count_reg == CNT_FULL);
   assign fifo_empty = (count_reg == '0);
   assign head_data  = fifo_mem[rd_ptr_reg];

   // A pop in the same cycle frees a slot, so a push to a full FIFO is
   // still accepted then; only an unrelieved full push is dropped.
   assign push_ok      = wr_txdata & (~fifo_full | pop);
   assign overflow_evt = wr_txdata & fifo_full & ~pop;

   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         fifo_mem[wr_ptr_reg] <= wdata_i[DATA_BITS-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         irq_en_reg   <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
         if (wr_status && wdata_i[3]) begin
            overflow_reg <= 1'b0;
         end else if (overflow_evt) begin
            overflow_reg <= 1'b1;
         end
         if (wr_ctrl) begin
            irq_en_reg <= wdata_i[0];
         end
      end
   end

   // ------------------------------------------------------------------
   // Frame FSM: state register
   // ------------------------------------------------------------------
   state_t               state_reg,    state_next;
   logic [BAUD_W-1:0]    baud_cnt_reg, baud_cnt_next;
   logic [BIT_W-1:0]     bit_idx_reg,  bit_idx_next;
   logic                 stop_idx_reg, stop_idx_next;
   logic [DATA_BITS-1:0] shift_reg,    shift_next;
   logic [DATA_BITS-1:0] frame_reg,    frame_next;
   logic                 tx_reg,       tx_next;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg    <= S_IDLE;
         baud_cnt_reg <= '0;
         bit_idx_reg  <= '0;
         stop_idx_reg <= 1'b0;
         shift_reg    <= '0;
         frame_reg    <= '0;
         tx_reg       <= 1'b1;
      end else begin
         state_reg    <= state_next;
         baud_cnt_reg <= baud_cnt_next;
         bit_idx_reg  <= bit_idx_next;
         stop_idx_reg <= stop_idx_next;
         shift_reg    <= shift_next;
         frame_reg    <= frame_next;
         tx_reg       <= tx_next;
      end
   end

   // ------------------------------------------------------------------
   // Frame FSM: next-state logic
   // ------------------------------------------------------------------
   logic bit_end;
   logic stop_last;

   assign bit_end   = (baud_cnt_reg == BAUD_LAST);
   assign stop_last = (STOP_BITS == 1) ? 1'b1 : stop_idx_reg;

   always_comb begin
      state_next    = state_reg;
      baud_cnt_next = baud_cnt_reg + BAUD_W'(1);
      bit_idx_next  = bit_idx_reg;
      stop_idx_next = stop_idx_reg;
      shift_next    = shift_reg;
      frame_next    = frame_reg;
      pop           = 1'b0;

      case (state_reg)
         S_IDLE: begin
            baud_cnt_next = '0;
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_next = head_data;
               frame_next = head_data;
               state_next = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               baud_cnt_next = '0;
               bit_idx_next  = '0;
               state_next    = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_cnt_next = '0;
               if (bit_idx_reg == BIT_LAST) begin
                  stop_idx_next = 1'b0;
                  state_next    = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_next = bit_idx_reg + BIT_W'(1);
                  shift_next   = {1'b0, shift_reg[DATA_BITS-1:1]};
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               baud_cnt_next = '0;
               stop_idx_next = 1'b0;
               state_next    = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               baud_cnt_next = '0;
               if (stop_last) begin
                  // Chain straight into the next frame when data is waiting.
                  if (!fifo_empty) begin
                     pop        = 1'b1;
                     shift_next = head_data;
                     frame_next = head_data;
                     state_next = S_START;
                  end else begin
                     state_next = S_IDLE;
                  end
               end else begin
                  stop_idx_next = 1'b1;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Frame FSM: outputs
   // ------------------------------------------------------------------
   logic parity_bit;

   assign parity_bit = (^frame_reg) ^ (PARITY_ODD != 0);

   // The line level is derived from the state being entered so the
   // registered tx_o changes on the same edge as the state does.
   always_comb begin
      tx_next = 1'b1;
      case (state_next)
         S_START:  tx_next = 1'b0;
         S_DATA:   tx_next = shift_next[0];
         S_PARITY: tx_next = parity_bit;
         default:  tx_next = 1'b1;
      endcase
   end

   assign tx_o   = tx_reg;
   assign busy_o = (state_reg != S_IDLE);
   assign irq_o  = irq_en_reg & fifo_empty & ~busy_o;

   // ------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------
   logic [7:0]    count_ext;
   logic [DW-1:0] status_word;

   assign count_ext = 8'(count_reg);

   genvar gi;
   generate
      for (gi = 0; gi < DW; gi++) begin : g_status
         if (gi == 0) begin : g_full
            assign status_word[gi] = fifo_full;
         end else if (gi == 1) begin : g_empty
            assign status_word[gi] = fifo_empty;
         end else if (gi == 2) begin : g_busy
            assign status_word[gi] = busy_o;
         end else if (gi == 3) begin : g_ovf
            assign status_word[gi] = overflow_reg;
         end else if (gi >= 8 && gi < 16) begin : g_count
            assign status_word[gi] = count_ext[gi-8];
         end else begin : g_zero
            assign status_word[gi] = 1'b0;
         end
      end
   endgenerate

   always_comb begin
      rdata_o = '0;
      if (cs_i && !we_i) begin
         case (addr_i)
            2'd1:    rdata_o = status_word;
            2'd2:    rdata_o = {{(DW-1){1'b0}}, irq_en_reg};
            default: rdata_o = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered. Four instances cover 8N1 with a 4-deep FIFO,
// even parity, odd parity and two stop bits. Line, busy and irq levels are
// logged once per clock; expected waveforms are built as bit lists from the
// frame rules and compared against the logs.
module tb_uart_tx_buffered;
   localparam int LOGN = 8192;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic [3:0]  cs    = '0;
   logic        we    = 1'b0;
   logic [1:0]  addr  = '0;
   logic [31:0] wdata = '0;

   wire [31:0] rdata_w [4];
   wire [3:0]  tx_w;
   wire [3:0]  busy_w;
   wire [3:0]  irq_w;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   logic log_tx   [4][LOGN];
   logic log_busy [4][LOGN];
   logic log_irq  [4][LOGN];

   bit exp_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // log[n] holds the level present after rising edge number n
   always @(negedge clk) begin
      if (cyc < LOGN) begin
         for (int i = 0; i < 4; i++) begin
            log_tx[i][cyc]   <= tx_w[i];
            log_busy[i][cyc] <= busy_w[i];
            log_irq[i][cyc]  <= irq_w[i];
         end
      end
   end

   uart_tx_buffered #(.DW(32), .CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8),
      .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
      .clk_i(clk), .rst_i(rst), .cs_i(cs[0]), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .rdata_o(rdata_w[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0]), .irq_o(irq_w[0]));

   uart_tx_buffered #(.DW(32), .CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8),
      .FIFO_DEPTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
      .clk_i(clk), .rst_i(rst), .cs_i(cs[1]), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .rdata_o(rdata_w[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1]), .irq_o(irq_w[1]));

   uart_tx_buffered #(.DW(32), .CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8),
      .FIFO_DEPTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
      .clk_i(clk), .rst_i(rst), .cs_i(cs[2]), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .rdata_o(rdata_w[2]), .tx_o(tx_w[2]), .busy_o(busy_w[2]), .irq_o(irq_w[2]));

   uart_tx_buffered #(.DW(32), .CLOCK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8),
      .FIFO_DEPTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
      .clk_i(clk), .rst_i(rst), .cs_i(cs[3]), .we_i(we), .addr_i(addr), .wdata_i(wdata),
      .rdata_o(rdata_w[3]), .tx_o(tx_w[3]), .busy_o(busy_w[3]), .irq_o(irq_w[3]));

   // ---------------- bus helpers and reference model ----------------
   task automatic bus_write(input logic [3:0] sel, input logic [1:0] a,
                            input logic [31:0] d, output int t);
      @(negedge clk);
      cs = sel; we = 1'b1; addr = a; wdata = d;
      @(posedge clk);
      #1;
      t = cyc;
      cs = '0; we = 1'b0;
   endtask

   task automatic bus_read(input int di, input logic [1:0] a, output logic [31:0] v);
      @(negedge clk);
      cs = 4'(1 << di); we = 1'b0; addr = a;
      #1;
      v = rdata_w[di];
      cs = '0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Appends one frame as per-clock line levels (10 clocks per bit).
   task automatic add_frame(input logic [7:0] d, input int pe, input int odd, input int sb);
      int ones;
      ones = 0;
      repeat (10) exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++) begin
         repeat (10) exp_q.push_back(d[b]);
         ones += int'(d[b]);
      end
      if (pe != 0) repeat (10) exp_q.push_back(bit'((ones % 2) ^ odd));
      repeat (10 * sb) exp_q.push_back(1'b1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      logic [31:0] v;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || irq_w[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_pins dut%0d tx/busy/irq got %b%b%b exp 100", i, tx_w[i], busy_w[i], irq_w[i]);
         end
         bus_read(i, 2'd1, v);
         checks++;
         if (v !== 32'h0000_0002) begin
            errors++;
            $display("FAIL reset_status dut%0d got %h exp %h", i, v, 32'h2);
         end
         bus_read(i, 2'd2, v);
         checks++;
         if (v !== 32'h0) begin
            errors++;
            $display("FAIL reset_ctrl dut%0d got %h exp 0", i, v);
         end
      end
   endtask

   task automatic test_regs;
      logic [31:0] v;
      int t, bad;
      bus_read(0, 2'd0, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL txdata_read got %h exp 0", v); end
      bus_read(0, 2'd3, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL addr3_read got %h exp 0", v); end
      @(negedge clk);
      cs = '0; we = 1'b0; addr = 2'd1;
      #1;
      checks++;
      if (rdata_w[0] !== 32'h0) begin errors++; $display("FAIL rdata_no_cs got %h exp 0", rdata_w[0]); end
      @(negedge clk);
      cs = 4'b0001; we = 1'b1; addr = 2'd1; wdata = 32'h0;
      #1;
      checks++;
      if (rdata_w[0] !== 32'h0) begin errors++; $display("FAIL rdata_during_write got %h exp 0", rdata_w[0]); end
      @(posedge clk);
      #1;
      cs = '0; we = 1'b0;
      bus_write(4'b0001, 2'd3, $urandom | 32'h1, t);
      wait_cycles(20);
      bad = 0;
      for (int k = t; k < t + 20; k++) if (log_tx[0][k] !== 1'b1 || log_busy[0][k] !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL addr3_write_line got %0d active clocks exp 0", bad); end
      bus_read(0, 2'd2, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL addr3_write_ctrl got %h exp 0", v); end
   endtask

   task automatic test_single_frame;
      logic [7:0] d;
      int t, bad;
      for (int n = 0; n < 3; n++) begin
         d = (n == 0) ? 8'hA5 : 8'($urandom);
         exp_q.delete();
         add_frame(d, 0, 0, 1);
         bus_write(4'b0001, 2'd0, {24'($urandom), d}, t);
         wait_cycles(105);
         bad = -1;
         for (int k = 0; k < exp_q.size(); k++)
            if (bad < 0 && log_tx[0][t+1+k] !== exp_q[k]) bad = k;
         checks++;
         if (bad >= 0) begin
            errors++;
            $display("FAIL frame_%02h clock %0d got %b exp %b", d, bad + 1, log_tx[0][t+1+bad], exp_q[bad]);
         end
         checks++;
         if (log_busy[0][t] !== 1'b0 || log_busy[0][t+1] !== 1'b1 || log_busy[0][t+100] !== 1'b1 || log_busy[0][t+101] !== 1'b0) begin
            errors++;
            $display("FAIL busy_%02h got t:%b t+1:%b t+100:%b t+101:%b exp 0110", d,
                     log_busy[0][t], log_busy[0][t+1], log_busy[0][t+100], log_busy[0][t+101]);
         end
         checks++;
         if (log_tx[0][t+101] !== 1'b1 || log_tx[0][t+104] !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_%02h got %b%b exp 11", d, log_tx[0][t+101], log_tx[0][t+104]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0]  bytes [6];
      logic [31:0] v;
      int t0, tt, bad;
      for (int run = 0; run < 2; run++) begin
         for (int j = 0; j < 6; j++) begin
            bytes[j] = (run == 0) ? 8'(j + 1) : 8'($urandom);
            bus_write(4'b0001, 2'd0, {24'h0, bytes[j]}, tt);
            if (j == 0) t0 = tt;
         end
         bus_read(0, 2'd1, v);
         checks++;
         if (v !== (32'h1 | 32'h4 | 32'h8 | (32'd4 << 8))) begin
            errors++;
            $display("FAIL b2b_status_full run%0d got %h exp %h", run, v, 32'h40D);
         end
         exp_q.delete();
         for (int j = 0; j < 5; j++) add_frame(bytes[j], 0, 0, 1);
         wait_cycles(510 - 6);
         bad = -1;
         for (int k = 0; k < exp_q.size(); k++)
            if (bad < 0 && log_tx[0][t0+1+k] !== exp_q[k]) bad = k;
         checks++;
         if (bad >= 0) begin
            errors++;
            $display("FAIL b2b_wave run%0d clock %0d got %b exp %b", run, bad + 1, log_tx[0][t0+1+bad], exp_q[bad]);
         end
         bad = 0;
         for (int k = t0 + 1; k <= t0 + 500; k++) if (log_busy[0][k] !== 1'b1) bad++;
         if (log_busy[0][t0+501] !== 1'b0 || log_tx[0][t0+501] !== 1'b1) bad++;
         checks++;
         if (bad != 0) begin errors++; $display("FAIL b2b_busy run%0d got %0d bad clocks exp 0", run, bad); end
         bus_read(0, 2'd1, v);
         checks++;
         if (v !== 32'h0000_000A) begin errors++; $display("FAIL b2b_status_done run%0d got %h exp %h", run, v, 32'hA); end
         bus_write(4'b0001, 2'd1, 32'h8, tt);
         bus_read(0, 2'd1, v);
         checks++;
         if (v !== 32'h0000_0002) begin errors++; $display("FAIL ovf_clear run%0d got %h exp %h", run, v, 32'h2); end
      end
   endtask

   task automatic test_parity;
      logic [7:0] pd   [6];
      int         pdut [6];
      int t, bad, odd, ones;
      bit pexp;
      pd[0] = 8'h07; pdut[0] = 1;
      pd[1] = 8'h03; pdut[1] = 2;
      pd[2] = 8'h07; pdut[2] = 2;
      for (int c = 3; c < 6; c++) begin pd[c] = 8'($urandom); pdut[c] = 1 + (c % 2); end
      for (int c = 0; c < 6; c++) begin
         odd  = (pdut[c] == 2) ? 1 : 0;
         ones = 0;
         for (int b = 0; b < 8; b++) ones += int'(pd[c][b]);
         pexp = bit'((ones % 2) ^ odd);
         exp_q.delete();
         add_frame(pd[c], 1, odd, 1);
         bus_write(4'(1 << pdut[c]), 2'd0, {24'h0, pd[c]}, t);
         wait_cycles(115);
         checks++;
         if (log_tx[pdut[c]][t+1+95] !== pexp) begin
            errors++;
            $display("FAIL parity_bit dut%0d data %02h got %b exp %b", pdut[c], pd[c], log_tx[pdut[c]][t+96], pexp);
         end
         bad = -1;
         for (int k = 0; k < exp_q.size(); k++)
            if (bad < 0 && log_tx[pdut[c]][t+1+k] !== exp_q[k]) bad = k;
         if (log_busy[pdut[c]][t+110] !== 1'b1 || log_busy[pdut[c]][t+111] !== 1'b0) bad = 999;
         checks++;
         if (bad >= 0) begin
            errors++;
            $display("FAIL parity_frame dut%0d data %02h first bad clock %0d", pdut[c], pd[c], bad + 1);
         end
      end
   endtask

   task automatic test_stop2;
      logic [7:0] d0, d1;
      int t, tt, bad, run, k;
      d0 = 8'($urandom) & 8'h7F;
      d1 = 8'($urandom);
      exp_q.delete();
      add_frame(d0, 0, 0, 2);
      add_frame(d1, 0, 0, 2);
      bus_write(4'b1000, 2'd0, {24'h0, d0}, t);
      bus_write(4'b1000, 2'd0, {24'h0, d1}, tt);
      wait_cycles(225);
      run = 0;
      k = t + 91;
      while (run < 100 && log_tx[3][k] === 1'b1) begin run++; k++; end
      checks++;
      if (run != 20) begin errors++; $display("FAIL stop2_gap got %0d high clocks exp 20", run); end
      bad = -1;
      for (int j = 0; j < exp_q.size(); j++)
         if (bad < 0 && log_tx[3][t+1+j] !== exp_q[j]) bad = j;
      checks++;
      if (bad >= 0) begin errors++; $display("FAIL stop2_wave clock %0d got %b exp %b", bad + 1, log_tx[3][t+1+bad], exp_q[bad]); end
      checks++;
      if (log_busy[3][t+150] !== 1'b1 || log_busy[3][t+220] !== 1'b1 || log_busy[3][t+221] !== 1'b0) begin
         errors++;
         $display("FAIL stop2_busy got %b%b%b exp 110", log_busy[3][t+150], log_busy[3][t+220], log_busy[3][t+221]);
      end
   endtask

   task automatic test_reset_midframe;
      logic [31:0] v;
      int t, tt, r, bad;
      bus_write(4'b0001, 2'd2, 32'h1, tt);
      exp_q.delete();
      add_frame(8'h55, 0, 0, 1);
      bus_write(4'b0001, 2'd0, 32'h55, t);
      bus_write(4'b0001, 2'd0, 32'hAA, tt);
      wait_cycles(34);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      r = cyc;
      checks++;
      if (log_tx[0][t+35] !== exp_q[34] || log_busy[0][t+35] !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_line got tx %b busy %b exp %b 1", log_tx[0][t+35], log_busy[0][t+35], exp_q[34]);
      end
      checks++;
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || irq_w[0] !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_pins got tx/busy/irq %b%b%b exp 100", tx_w[0], busy_w[0], irq_w[0]);
      end
      bus_read(0, 2'd1, v);
      checks++;
      if (v !== 32'h0000_0002) begin errors++; $display("FAIL post_reset_status got %h exp %h", v, 32'h2); end
      bus_read(0, 2'd2, v);
      checks++;
      if (v !== 32'h0) begin errors++; $display("FAIL post_reset_ctrl got %h exp 0", v); end
      wait_cycles(200);
      bad = 0;
      for (int k = r; k < r + 200; k++) if (log_tx[0][k] !== 1'b1 || log_busy[0][k] !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL post_reset_quiet got %0d active clocks exp 0", bad); end
   endtask

   task automatic test_irq;
      int t, tt, w, bad;
      bus_write(4'b0001, 2'd2, 32'h1, tt);
      checks++;
      if (irq_w[0] !== 1'b1) begin errors++; $display("FAIL irq_idle got %b exp 1", irq_w[0]); end
      bus_write(4'b0001, 2'd0, 32'h3C, t);
      wait_cycles(105);
      bad = 0;
      for (int k = t; k <= t + 100; k++) if (log_irq[0][k] !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL irq_in_frame got %0d high clocks exp 0", bad); end
      checks++;
      if (log_irq[0][t+101] !== 1'b1 || irq_w[0] !== 1'b1) begin
         errors++;
         $display("FAIL irq_done got %b/%b exp 1/1", log_irq[0][t+101], irq_w[0]);
      end
      bus_write(4'b0001, 2'd0, $urandom, w);
      wait_cycles(1);
      checks++;
      if (log_irq[0][w-1] !== 1'b1 || log_irq[0][w] !== 1'b0) begin
         errors++;
         $display("FAIL irq_clear got before %b after %b exp 1 0", log_irq[0][w-1], log_irq[0][w]);
      end
      wait_cycles(105);
      checks++;
      if (irq_w[0] !== 1'b1) begin errors++; $display("FAIL irq_second_done got %b exp 1", irq_w[0]); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      test_reset();
      test_regs();
      test_single_frame();
      test_back_to_back();
      test_parity();
      test_stop2();
      test_reset_midframe();
      test_irq();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
